// File: rtl/apb_master_bridge.sv
`timescale 1ns/1ps
// Single-outstanding APB3 requester: valid/ready command in, buffered response out.
// Adds address-window decode, a pready timeout and transaction/error counters.
module apb_master_bridge #(
  parameter logic [31:0] ADDR_BASE      = 32'h4000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMER_W        = 9
) (
  input  logic        clk_periph_100mhz,
  input  logic        rst_periph_domain_async,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slverr,
  output logic        rsp_timeout,
  output logic [31:0] apb_paddr,
  output logic        apb_psel_qualified,
  output logic        apb_penable_sync,
  output logic        apb_pwrite_direction,
  output logic [31:0] apb_pwdata,
  input  logic [31:0] apb_prdata,
  input  logic        apb_pready_response,
  input  logic        apb_pslverr_indicator,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic                  TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned           TIMER_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TIMER_W-1:0]    TIMER_LAST   = TIMER_LAST_I[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0]    TIMER_ONE    = {{(TIMER_W-1){1'b0}}, 1'b1};

  // Word-aligned and inside the peripheral window.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a & ADDR_MASK) == ADDR_BASE);
  endfunction

  state_t             r_state;
  logic               r_req_ready;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_write;
  logic               r_psel;
  logic               r_penable;
  logic [TIMER_W-1:0] r_timer;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_slverr;
  logic               r_rsp_timeout;
  logic [15:0]        r_txn_count;
  logic [7:0]         r_err_count;
  logic               w_accept;

  assign w_accept = req_valid && r_req_ready;

  // Transfer FSM with every output registered.
  always_ff @(posedge clk_periph_100mhz or posedge rst_periph_domain_async) begin
    if (rst_periph_domain_async) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b0;
      r_addr        <= 32'h0000_0000;
      r_wdata       <= 32'h0000_0000;
      r_write       <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_timer       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'h0000_0000;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_txn_count   <= 16'h0000;
      r_err_count   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_write     <= req_write;
            if (addr_ok(req_addr)) begin
              r_psel  <= 1'b1;
              r_state <= ST_SETUP;
            end else begin
              // Decode error: answer locally without touching the bus.
              r_rsp_valid   <= 1'b1;
              r_rsp_rdata   <= 32'h0000_0000;
              r_rsp_slverr  <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_state       <= ST_RESP;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_timer   <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apb_pready_response) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= (!r_write && !apb_pslverr_indicator) ? apb_prdata : 32'h0000_0000;
            r_rsp_slverr  <= apb_pslverr_indicator;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RESP;
          end else if (TIMEOUT_EN && (r_timer == TIMER_LAST)) begin
            // This is the last stalled cycle allowed; abandon the transfer.
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= 32'h0000_0000;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_txn_count <= r_txn_count + 16'd1;
            if (r_rsp_slverr && (r_err_count != 8'hFF)) begin
              r_err_count <= r_err_count + 8'd1;
            end else begin
              r_err_count <= r_err_count;
            end
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready            = r_req_ready;
  assign rsp_valid            = r_rsp_valid;
  assign rsp_rdata            = r_rsp_rdata;
  assign rsp_slverr           = r_rsp_slverr;
  assign rsp_timeout          = r_rsp_timeout;
  assign apb_paddr            = r_addr;
  assign apb_psel_qualified   = r_psel;
  assign apb_penable_sync     = r_penable;
  assign apb_pwrite_direction = r_write;
  assign apb_pwdata           = r_wdata;
  assign txn_count            = r_txn_count;
  assign err_count            = r_err_count;

endmodule

// File: tb/tb_apb_master_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for apb_master_bridge: directed commands push expected
// responses; a monitor pops and compares on every response handshake.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
  logic        apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   wait_cfg = 0;
  int   acc_cnt  = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_BASE(32'h4000_0000), .ADDR_MASK(32'hFFFF_0000),
    .TIMEOUT_CYCLES(4), .TIMER_W(9)
  ) dut (
    .clk_periph_100mhz(clk), .rst_periph_domain_async(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .apb_paddr(apb_paddr), .apb_psel_qualified(apb_psel),
    .apb_penable_sync(apb_penable), .apb_pwrite_direction(apb_pwrite),
    .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready_response(apb_pready), .apb_pslverr_indicator(apb_pslverr),
    .txn_count(txn_count), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // APB completer model: pready after wait_cfg stalled ACCESS cycles.
  initial begin
    apb_pready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (apb_psel && apb_penable) begin
        apb_pready = (acc_cnt == wait_cfg);
        acc_cnt++;
      end else begin
        apb_pready = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        chk("no_psel_with_rsp", 64'(apb_psel), 64'd0);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp actual=%0h required=none", rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("rsp", 64'({rsp_rdata, rsp_slverr, rsp_timeout}), 64'(e));
          end
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eslv, input logic eto);
    int   n;
    exp_t e;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL issue_wait actual=req_ready_low required=req_ready_high");
    end
    e.rdata   = erd;
    e.slverr  = eslv;
    e.timeout = eto;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(req_ready && !rsp_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("wait_idle", 64'(req_ready), 64'd1);
  endtask

  task automatic count_psel(output int n, input logic [31:0] a, input logic [31:0] d,
                            input logic w);
    n = 0;
    while (apb_psel && n < 50) begin
      chk("paddr_stable", 64'(apb_paddr), 64'(a));
      chk("pwdata_stable", 64'(apb_pwdata), 64'(d));
      chk("pwrite_stable", 64'(apb_pwrite), 64'(w));
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b1; apb_prdata = 32'h0; apb_pslverr = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_psel", 64'(apb_psel), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_txn", 64'(txn_count), 64'd0);
    rst = 1'b0;
    tick();
    chk("req_ready_after_rst", 64'(req_ready), 64'd1);

    // Zero-wait read latency.
    apb_prdata = 32'hCAFE_F00D; wait_cfg = 0;
    issue(1'b0, 32'h4000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    chk("t1_psel", 64'(apb_psel), 64'd1);
    chk("t1_penable_setup", 64'(apb_penable), 64'd0);
    chk("t1_paddr", 64'(apb_paddr), 64'h4000_0010);
    tick();
    chk("t1_penable", 64'(apb_penable), 64'd1);
    tick();
    chk("t1_psel_drop", 64'(apb_psel), 64'd0);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    tick();
    chk("t1_txn", 64'(txn_count), 64'd1);
    wait_idle();

    // Write with three wait states; also pready on the would-be abort cycle.
    wait_cfg = 3;
    issue(1'b1, 32'h4000_0020, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    count_psel(n, 32'h4000_0020, 32'h1234_5678, 1'b1);
    chk("t2_psel_cycles", 64'(n), 64'd5);
    wait_idle();

    // Decode errors: out of window and misaligned.
    wait_cfg = 0;
    issue(1'b0, 32'h5000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t3_no_psel_a", 64'(apb_psel), 64'd0);
    chk("t3_rsp_valid_a", 64'(rsp_valid), 64'd1);
    wait_idle();
    issue(1'b0, 32'h4000_0002, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t3_no_psel_b", 64'(apb_psel), 64'd0);
    wait_idle();
    chk("t3_err", 64'(err_count), 64'd2);
    chk("t3_txn", 64'(txn_count), 64'd4);

    // Timeout, then pslverr.
    wait_cfg = 1000;
    issue(1'b0, 32'h4000_0100, 32'h0, 32'h0, 1'b1, 1'b1);
    count_psel(n, 32'h4000_0100, 32'h0, 1'b0);
    chk("t4_psel_cycles", 64'(n), 64'd5);
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    wait_idle();
    apb_pslverr = 1'b1; wait_cfg = 1;
    issue(1'b0, 32'h4000_0200, 32'h0, 32'h0, 1'b1, 1'b0);
    wait_idle();
    apb_pslverr = 1'b0;
    chk("t4_err", 64'(err_count), 64'd4);

    // Response backpressure with a pending command.
    wait_cfg = 0; apb_prdata = 32'h1111_2222; rsp_ready = 1'b0;
    issue(1'b0, 32'h4000_0030, 32'h0, 32'h1111_2222, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    req_write = 1'b1; req_addr = 32'h4000_0004; req_wdata = 32'hA5A5_A5A5; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t5_rdata", 64'(rsp_rdata), 64'h1111_2222);
      chk("t5_req_ready", 64'(req_ready), 64'd0);
      chk("t5_psel", 64'(apb_psel), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    issue(1'b1, 32'h4000_0004, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
    wait_idle();
    chk("t5_txn", 64'(txn_count), 64'd8);

    // Asynchronous reset in ACCESS.
    wait_cfg = 1000;
    issue(1'b0, 32'h4000_0040, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    chk("t6_in_access", 64'(apb_penable), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_psel", 64'(apb_psel), 64'd0);
    chk("t6_penable", 64'(apb_penable), 64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_txn", 64'(txn_count), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    wait_cfg = 0;
    tick();
    chk("t6_req_ready", 64'(req_ready), 64'd1);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      issue(1'b0, 32'h6000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
      wait_idle();
    end
    chk("t7_err_sat", 64'(err_count), 64'hFF);
    chk("t7_txn", 64'(txn_count), 64'd300);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
